// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default divisor width, line idle level.
package uart_pkg;

  localparam int DIV_WIDTH_DEF = 16;
  localparam logic LINE_IDLE = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period counter: counts 0..div_i-1 while enabled and pulses tc_o on the last cycle.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tc_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  assign tc_o = en_i & (cnt_q == (div_i - DIV_WIDTH'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter popping words from a FIFO with asynchronous read and sending them LSB first.
// Optional parity bit between data and stop is enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = DIV_WIDTH_DEF
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tx_en_i,
  input  logic [DIV_WIDTH-1:0]  clk_div_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  fifo_rd_en_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic                  tx_q, tx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif
  logic                  pop;
  logic                  tc;

  // Reset is folded in so no pop can be seen by the FIFO while the transmitter is held.
  assign pop          = (state_q == S_IDLE) & tx_en_i & ~fifo_empty_i & ~rst_i;
  assign fifo_rd_en_o = pop;
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != S_IDLE);

  uart_baud_cnt #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (pop),
    .en_i  (state_q != S_IDLE),
    .div_i (div_q),
    .tc_o  (tc)
  );

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    div_d    = div_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d  = S_START;
          tx_d     = 1'b0;
          shift_d  = fifo_rd_data_i;
          bit_d    = '0;
          div_d    = (clk_div_i == '0) ? DIV_WIDTH'(1) : clk_div_i;
`ifdef UART_TX_PARITY_EN
          parity_d = (^fifo_rd_data_i) ^ PARITY_ODD;
`endif
        end
      end
      S_START: begin
        if (tc) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (tc) begin
          if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = LINE_IDLE;
`endif
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tc) begin
          state_d = S_STOP;
          tx_d    = LINE_IDLE;
        end
      end
`endif
      S_STOP: begin
        if (tc) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      tx_q     <= LINE_IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      div_q    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Self-checking bench for uart_tx_fifo_drain: a frame-level line model fed by a queue FIFO plus directed literal checks.
module tb_uart_tx_fifo_drain;

  localparam int DW = 8;
  localparam int VW = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit          PODD    = 1'b0;
  localparam int          NB      = DW + 3;
  localparam int          T1_BUSY = 44;
  localparam int          T2_SP   = 23;
  localparam logic [15:0] T1_EXP  = 16'b00000_10010101010;
  localparam logic [15:0] T2_EXP  = 16'b00000_10000011110;
  localparam logic [15:0] T3_EXP  = 16'b00000_10111111110;
  localparam logic [15:0] T5_EXP  = 16'b00000_10100110010;
`else
  localparam int          NB      = DW + 2;
  localparam int          T1_BUSY = 40;
  localparam int          T2_SP   = 21;
  localparam logic [15:0] T1_EXP  = 16'b000000_1010101010;
  localparam logic [15:0] T2_EXP  = 16'b000000_1000011110;
  localparam logic [15:0] T3_EXP  = 16'b000000_1111111110;
  localparam logic [15:0] T5_EXP  = 16'b000000_1100110010;
`endif

  logic          clk = 1'b0;
  logic          rst_i;
  logic          tx_en_i;
  logic [VW-1:0] clk_div_i;
  logic          fifo_empty_i;
  logic [DW-1:0] fifo_rd_data_i;
  logic          fifo_rd_en_o;
  logic          tx_o;
  logic          busy_o;

  always #5 clk = ~clk;

  uart_tx_fifo_drain #(
    .DATA_WIDTH (DW),
    .DIV_WIDTH  (VW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .tx_en_i        (tx_en_i),
    .clk_div_i      (clk_div_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_rd_data_i (fifo_rd_data_i),
    .fifo_rd_en_o   (fifo_rd_en_o),
    .tx_o           (tx_o),
    .busy_o         (busy_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] fifo_q[$];
  bit            line_q[$];
  bit            exp_rd_q = 1'b0;
  int            busy_cnt = 0;
  int            pop_pos[$];
  bit            hist[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty_i   = (fifo_q.size() == 0);
    fifo_rd_data_i = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    drive_fifo();
  endtask

  // Whole frame as a list of per-cycle line levels, built when the pop is expected.
  task automatic model_step();
    logic [DW-1:0] w;
    int d;
    if (rst_i) begin
      line_q.delete();
    end else if (exp_rd_q) begin
      w = fifo_q.pop_front();
      d = (clk_div_i == '0) ? 1 : int'(clk_div_i);
      for (int r = 0; r < d; r++) line_q.push_back(1'b0);
      for (int b = 0; b < DW; b++)
        for (int r = 0; r < d; r++) line_q.push_back(w[b]);
`ifdef UART_TX_PARITY_EN
      for (int r = 0; r < d; r++) line_q.push_back((^w) ^ PODD);
`endif
      for (int r = 0; r < d; r++) line_q.push_back(1'b1);
      drive_fifo();
    end else if (line_q.size() != 0) begin
      void'(line_q.pop_front());
    end
  endtask

  always @(negedge clk) begin : compare
    bit er, et, eb;
    er = !rst_i && (line_q.size() == 0) && tx_en_i && (fifo_q.size() != 0);
    et = (rst_i || line_q.size() == 0) ? 1'b1 : line_q[0];
    eb = !rst_i && (line_q.size() != 0);
    check("rd_en", fifo_rd_en_o, er);
    check("tx", tx_o, et);
    check("busy", busy_o, eb);
    exp_rd_q = er;
    if (fifo_rd_en_o) pop_pos.push_back(hist.size() + 1);
    hist.push_back(tx_o);
    if (busy_o) busy_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    busy_cnt = 0;
    pop_pos.delete();
    hist.delete();
  endtask

  task automatic wait_drain(input int limit, input string nm);
    int i = 0;
    while ((line_q.size() != 0 || fifo_q.size() != 0) && i < limit) begin
      step();
      i++;
    end
    check({nm, "_drain"}, line_q.size() + fifo_q.size(), 0);
  endtask

  function automatic logic samp(input int i);
    return (i >= 0 && i < hist.size()) ? logic'(hist[i]) : 1'bx;
  endfunction

  // Mid-bit sample of each of n bit periods starting at log index p.
  function automatic logic [15:0] frame_bits(input int p, input int d, input int n);
    logic [15:0] v = '0;
    for (int k = 0; k < n; k++) v[k] = samp(p + k * d + d / 2);
    return v;
  endfunction

  function automatic int pos(input int k);
    return (pop_pos.size() > k) ? pop_pos[k] : -1000;
  endfunction

  initial begin
    int h0;
    rst_i     = 1'b1;
    tx_en_i   = 1'b0;
    clk_div_i = 16'd4;
    drive_fifo();
    run(3);
    check("reset_tx", tx_o, 1'b1);
    check("reset_busy", busy_o, 1'b0);
    check("reset_rd_en", fifo_rd_en_o, 1'b0);
    rst_i = 1'b0;

    // Single frame 0x55, 4 clk per bit
    clear_logs();
    push_word(8'h55);
    tx_en_i = 1'b1;
    run(60);
    check("t1_pops", pop_pos.size(), 1);
    check("t1_busy", busy_cnt, T1_BUSY);
    check("t1_frame", frame_bits(pos(0), 4, NB), T1_EXP);

    // Back-to-back 0xA3, 0x0F, 2 clk per bit
    clear_logs();
    clk_div_i = 16'd2;
    push_word(8'hA3);
    push_word(8'h0F);
    wait_drain(200, "t2");
    run(3);
    check("t2_pops", pop_pos.size(), 2);
    check("t2_spacing", pos(1) - pos(0), T2_SP);
    check("t2_gap_level", samp(pos(1) - 1), 1'b1);
    check("t2_start2", samp(pos(1)), 1'b0);
    check("t2_frame2", frame_bits(pos(1), 2, NB), T2_EXP);

    // Divisor zero behaves as one
    clear_logs();
    clk_div_i = 16'd0;
    push_word(8'hFF);
    wait_drain(100, "t3");
    run(3);
    check("t3_busy", busy_cnt, NB);
    check("t3_frame", frame_bits(pos(0), 1, NB), T3_EXP);

    // Enable gating
    clear_logs();
    tx_en_i   = 1'b0;
    clk_div_i = 16'd3;
    push_word(8'h3C);
    run(40);
    check("t4_no_pop", pop_pos.size(), 0);
    check("t4_no_busy", busy_cnt, 0);
    tx_en_i = 1'b1;
    run(5);
    tx_en_i = 1'b0;
    push_word(8'hC3);
    run(60);
    check("t4_one_pop", pop_pos.size(), 1);
    check("t4_busy", busy_cnt, NB * 3);
    h0 = hist.size();
    tx_en_i = 1'b1;
    wait_drain(100, "t4");
    run(3);
    check("t4_resume_pops", pop_pos.size(), 2);
    check("t4_resume_latency", pos(1), h0 + 1);

    // Asynchronous reset during the data bits
    clear_logs();
    clk_div_i = 16'd3;
    push_word(8'h5A);
    push_word(8'h99);
    run(15);
    check("t5_busy_before", busy_o, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    check("t5_tx_async", tx_o, 1'b1);
    check("t5_busy_async", busy_o, 1'b0);
    check("t5_rd_en_async", fifo_rd_en_o, 1'b0);
    step();
    step();
    rst_i = 1'b0;
    clear_logs();
    wait_drain(100, "t5");
    run(3);
    check("t5_pops_after", pop_pos.size(), 1);
    check("t5_frame", frame_bits(pos(0), 3, NB), T5_EXP);

`ifdef UART_TX_PARITY_EN
    // Even parity of 0x07 is 1
    clear_logs();
    clk_div_i = 16'd3;
    push_word(8'h07);
    wait_drain(100, "t6");
    run(3);
    check("t6_busy", busy_cnt, 33);
    check("t6_parity", samp(pos(0) + 9 * 3 + 1), 1'b1);
`endif

    // Random traffic, enable toggling, divisor changes and occasional reset
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 29) == 0) push_word(DW'($urandom));
      if ($urandom_range(0, 63) == 0) tx_en_i = ~tx_en_i;
      if ($urandom_range(0, 15) == 0) clk_div_i = VW'($urandom_range(0, 4));
      if ($urandom_range(0, 799) == 0) begin
        #2;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
      end
    end
    tx_en_i = 1'b1;
    wait_drain(20000, "rand");
    run(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
